eth_tx_frame_arbiter: RTL and testbench



---
 rtl/eth_tx_arb_pkg.sv | 19 +
 rtl/arb_rr_select.sv | 33 +++
 rtl/eth_tx_frame_arbiter.sv | 151 +++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arb_pkg.sv
// Shared types and constants for the TX frame arbiter and its round-robin selector.
package eth_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } arb_state_e;

  localparam int DEFAULT_MAX_FRAME_LEN = 1518;

  // Index base+off folded back into 0..n-1; off is always below n.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Combinational round-robin select: first set request at or after ptr_i, wrapping.
// Zero latency; pure function of its inputs, no backpressure.
module arb_rr_select
  import eth_tx_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  logic hit;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!hit && req_i[wrap_idx(int'(ptr_i), k, N)]) begin
        hit = 1'b1;
        gnt_o[wrap_idx(int'(ptr_i), k, N)] = 1'b1;
        idx_o = IDX_W'(wrap_idx(int'(ptr_i), k, N));
      end
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the MAC TX FIFO; truncates oversize frames.
// One idle arbitration cycle per frame; data path is combinational, tready passes straight back.
module eth_tx_frame_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int S_COUNT       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = DEFAULT_MAX_FRAME_LEN,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                          logic_clk,
  input  logic                          logic_rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT-1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic                          cfg_enable,
  output logic [S_COUNT-1:0]            grant,
  output logic                          grant_valid,
  output logic                          status_oversize
);

  localparam int IDX_W = $clog2(S_COUNT);
  localparam logic [LEN_WIDTH-1:0] LAST_BEAT = LEN_WIDTH'(MAX_FRAME_LEN - 1);

  arb_state_e           state_q, state_d;
  logic [S_COUNT-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 oversize_q, oversize_d;

  logic [S_COUNT-1:0]    sel_gnt;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_vld;
  logic                  g_vld, g_last, g_user;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  at_limit, m_hs;
  logic [IDX_W-1:0]      next_rr;

  arb_rr_select #(
    .N     (S_COUNT),
    .IDX_W (IDX_W)
  ) u_sel (
    .req_i (s_axis_tvalid),
    .ptr_i (rr_q),
    .gnt_o (sel_gnt),
    .idx_o (sel_idx),
    .vld_o (sel_vld)
  );

  assign g_vld    = s_axis_tvalid[gidx_q];
  assign g_last   = s_axis_tlast[gidx_q];
  assign g_user   = s_axis_tuser[gidx_q];
  assign g_data   = s_axis_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
  // Counter holds beats already forwarded, so at_limit marks the last allowed beat.
  assign at_limit = (cnt_q == LAST_BEAT);
  assign m_hs     = (state_q == ST_ACTIVE) && g_vld && m_axis_tready;
  assign next_rr  = (gidx_q == IDX_W'(S_COUNT - 1)) ? '0 : gidx_q + 1'b1;

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      oversize_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      oversize_q <= oversize_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    oversize_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_enable && sel_vld) begin
          state_d = ST_ACTIVE;
          grant_d = sel_gnt;
          gidx_d  = sel_idx;
          cnt_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (m_hs) begin
          cnt_d = cnt_q + 1'b1;
          if (g_last) begin
            state_d = ST_IDLE;
            grant_d = '0;
            rr_d    = next_rr;
          end else if (at_limit) begin
            state_d    = ST_DROP;
            oversize_d = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (g_vld && g_last) begin
          state_d = ST_IDLE;
          grant_d = '0;
          rr_d    = next_rr;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    case (state_q)
      ST_ACTIVE: begin
        m_axis_tdata  = g_data;
        m_axis_tvalid = g_vld;
        m_axis_tlast  = g_last || at_limit;
        m_axis_tuser  = g_user || (at_limit && !g_last);
        s_axis_tready = grant_q & {S_COUNT{m_axis_tready}};
      end
      ST_DROP: s_axis_tready = grant_q;
      default: s_axis_tready = '0;
    endcase
  end

  assign grant           = grant_q;
  assign grant_valid     = (state_q != ST_IDLE);
  assign status_oversize = oversize_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: arbitration vector table plus frame-level sequences.
module tb_eth_tx_frame_arbiter;

  localparam int S    = 4;
  localparam int DW   = 8;
  localparam int MAXL = 1518;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [S*DW-1:0] s_axis_tdata;
  logic [S-1:0]  s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic          cfg_enable;
  logic [S-1:0]  grant;
  logic          grant_valid, status_oversize;

  always #5 clk = ~clk;

  eth_tx_frame_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(DW), .MAX_FRAME_LEN(MAXL), .LEN_WIDTH(16)
  ) dut (
    .logic_clk(clk), .logic_rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .cfg_enable(cfg_enable), .grant(grant), .grant_valid(grant_valid),
    .status_oversize(status_oversize)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Source model: per-stream frame generator advanced on observed handshakes.
  int   src_len[S], src_beat[S], src_frm[S], src_left[S];
  logic src_user[S];
  logic [S-1:0] hs_q;
  bit   rand_rdy, mirror_chk;
  int   ovs_cnt, mirror_errs;
  logic gv_prev;
  logic [DW-1:0] out_dat[$];
  logic out_last[$], out_user[$];
  int   glog[$];

  function automatic logic [7:0] pat(input int s, input int f, input int b);
    return 8'(b * 7 + f * 31 + s * 64);
  endfunction

  task automatic drive();
    for (int i = 0; i < S; i++) begin
      s_axis_tvalid[i] = (src_left[i] > 0);
      s_axis_tlast[i]  = (src_beat[i] == src_len[i] - 1);
      s_axis_tuser[i]  = src_user[i] && (src_beat[i] == src_len[i] - 1);
      s_axis_tdata[i*DW +: DW] = pat(i, src_frm[i], src_beat[i]);
    end
  endtask

  task automatic load(input int s, input int len, input int nfr, input logic user);
    src_len[s]  = len;
    src_beat[s] = 0;
    src_left[s] = nfr;
    src_user[s] = user;
  endtask

  task automatic sample();
    int gi;
    hs_q = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      out_dat.push_back(m_axis_tdata);
      out_last.push_back(m_axis_tlast);
      out_user.push_back(m_axis_tuser);
    end
    if (status_oversize) ovs_cnt++;
    if (grant_valid && !gv_prev) begin
      gi = -1;
      for (int i = 0; i < S; i++) if (grant[i]) gi = i;
      glog.push_back(gi);
    end
    gv_prev = grant_valid;
    if (mirror_chk && (s_axis_tready !== (grant & {S{m_axis_tready}}))) mirror_errs++;
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < S; i++) begin
      if (hs_q[i]) begin
        src_beat[i]++;
        if (src_beat[i] == src_len[i]) begin
          src_beat[i] = 0;
          src_frm[i]++;
          src_left[i]--;
        end
      end
    end
    hs_q = '0;
    if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    drive();
    @(negedge clk);
    sample();
  endtask

  function automatic bit busy();
    bit b;
    b = grant_valid;
    for (int i = 0; i < S; i++) if (src_left[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(busy()), 0);
  endtask

  task automatic chk_frame(input string name, input int s, input int f, input int len, input logic user);
    int fwd, errs;
    bit trunc;
    logic [DW-1:0] d;
    logic l, u, el, eu;
    fwd   = (len > MAXL) ? MAXL : len;
    trunc = (len > MAXL);
    errs  = 0;
    for (int b = 0; b < fwd; b++) begin
      if (out_dat.size() == 0) begin
        errs++;
        break;
      end
      d  = out_dat.pop_front();
      l  = out_last.pop_front();
      u  = out_user.pop_front();
      el = (b == fwd - 1);
      eu = trunc ? (b == fwd - 1) : (user && (b == len - 1));
      if (d !== pat(s, f, b) || l !== el || u !== eu) errs++;
    end
    chk(name, errs, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cfg_enable = 1'b1;
    m_axis_tready = 1'b1;
    rand_rdy = 0;
    mirror_chk = 0;
    for (int i = 0; i < S; i++) begin
      src_len[i] = 1; src_beat[i] = 0; src_frm[i] = 0; src_left[i] = 0; src_user[i] = 1'b0;
    end
    drive();
    hs_q = '0;
    out_dat.delete(); out_last.delete(); out_user.delete(); glog.delete();
    ovs_cnt = 0;
    gv_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [S-1:0] mask;
    logic         cfg;
    logic         user;
    logic [S-1:0] exp_g;
    logic [7:0]   exp_d;
  } vec_t;

  vec_t tv[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    // Pointer evolves across vectors; each entry's expectation follows from the previous grant.
    tv[0]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 8'hA0};
    tv[1]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 8'hA0};
    tv[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 8'hA1};
    tv[3]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 8'hA2};
    tv[4]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 8'hA3};
    tv[5]  = '{4'b1010, 1'b1, 1'b0, 4'b0010, 8'hA1};
    tv[6]  = '{4'b0011, 1'b1, 1'b0, 4'b0001, 8'hA0};
    tv[7]  = '{4'b1000, 1'b1, 1'b1, 4'b1000, 8'hA3};
    tv[8]  = '{4'b0110, 1'b1, 1'b0, 4'b0010, 8'hA1};
    tv[9]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 8'h00};
    tv[10] = '{4'b1011, 1'b1, 1'b0, 4'b1000, 8'hA3};
    tv[11] = '{4'b0101, 1'b1, 1'b0, 4'b0001, 8'hA0};

    // Reset state, with requests already pending.
    rst_n = 1'b0;
    cfg_enable = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tvalid = '1;
    s_axis_tlast = '0;
    s_axis_tuser = '1;
    s_axis_tdata = '1;
    @(negedge clk); @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_gv", grant_valid, 0);
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_mlast", m_axis_tlast, 0);
    chk("rst_muser", m_axis_tuser, 0);
    chk("rst_sready", s_axis_tready, 0);
    chk("rst_ovs", status_oversize, 0);
    s_axis_tvalid = '0;
    rst_n = 1'b1;

    // Arbitration table: single-beat frames, one per vector.
    for (int v = 0; v < 12; v++) begin
      @(posedge clk); #1;
      s_axis_tvalid = tv[v].mask;
      s_axis_tlast  = '1;
      s_axis_tuser  = tv[v].user ? '1 : '0;
      cfg_enable    = tv[v].cfg;
      for (int i = 0; i < S; i++) s_axis_tdata[i*DW +: DW] = 8'hA0 + 8'(i);
      @(negedge clk);
      chk($sformatf("tv%0d_arb_grant", v), grant, 0);
      chk($sformatf("tv%0d_arb_ready", v), s_axis_tready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("tv%0d_grant", v), grant, tv[v].exp_g);
      chk($sformatf("tv%0d_gv", v), grant_valid, 32'(tv[v].exp_g != 0));
      chk($sformatf("tv%0d_mvalid", v), m_axis_tvalid, 32'(tv[v].exp_g != 0));
      chk($sformatf("tv%0d_muser", v), m_axis_tuser, 32'((tv[v].exp_g != 0) && tv[v].user));
      chk($sformatf("tv%0d_sready", v), s_axis_tready, tv[v].exp_g);
      if (tv[v].exp_g != 0) chk($sformatf("tv%0d_mdata", v), m_axis_tdata, tv[v].exp_d);
      @(posedge clk); #1;
      s_axis_tvalid = '0;
      @(negedge clk);
      chk($sformatf("tv%0d_release", v), grant_valid, 0);
    end

    // Single 64-beat frame from stream 0, then pointer has moved to 1.
    do_reset();
    load(0, 64, 1, 1'b0); drive(); #1; sample();
    chk("t1_arb_wait", grant, 0);
    step();
    chk("t1_grant", grant, 4'b0001);
    chk("t1_mvalid", m_axis_tvalid, 1);
    run_idle(200, "t1_done");
    chk_frame("t1_frame", 0, 0, 64, 1'b0);
    chk("t1_extra", out_dat.size(), 0);
    load(0, 4, 1, 1'b0); load(1, 4, 1, 1'b0); drive(); #1; sample();
    step();
    chk("t1_rr_next", grant, 4'b0010);
    run_idle(100, "t1_rr_done");
    chk_frame("t1_rr_f1", 1, 0, 4, 1'b0);
    chk_frame("t1_rr_f0", 0, 1, 4, 1'b0);

    // Streams 0 and 2 continuously requesting alternate.
    do_reset();
    load(0, 5, 3, 1'b0); load(2, 5, 3, 1'b0); drive(); #1; sample();
    run_idle(300, "t2_done");
    chk("t2_ngrants", glog.size(), 6);
    for (int k = 0; k < glog.size() && k < 6; k++) chk($sformatf("t2_order%0d", k), glog[k], (k % 2) ? 2 : 0);
    for (int k = 0; k < 6; k++) chk_frame($sformatf("t2_frame%0d", k), (k % 2) ? 2 : 0, k / 2, 5, 1'b0);

    // Oversize 1600-beat frame is truncated at 1518, remainder dropped.
    ovs_cnt = 0;
    load(1, 1600, 1, 1'b0); drive(); #1; sample();
    run_idle(2000, "t3_done");
    chk_frame("t3_trunc", 1, 0, 1600, 1'b0);
    chk("t3_extra", out_dat.size(), 0);
    chk("t3_ovs", ovs_cnt, 1);

    // Exactly MAX beats is legal; one more beat truncates.
    ovs_cnt = 0;
    load(3, 1518, 1, 1'b0); drive(); #1; sample();
    run_idle(2000, "t4_done");
    chk_frame("t4_exact", 3, 0, 1518, 1'b0);
    chk("t4_ovs", ovs_cnt, 0);
    load(2, 1519, 1, 1'b1); drive(); #1; sample();
    run_idle(2000, "t4b_done");
    chk_frame("t4b_trunc", 2, 3, 1519, 1'b1);
    chk("t4b_extra", out_dat.size(), 0);
    chk("t4b_ovs", ovs_cnt, 1);

    // Random downstream backpressure with all four streams requesting.
    do_reset();
    rand_rdy = 1;
    mirror_chk = 1;
    mirror_errs = 0;
    for (int i = 0; i < S; i++) load(i, 6 + 3 * i, 2, 1'(i == 1));
    drive(); #1; sample();
    run_idle(2000, "t5_done");
    rand_rdy = 0;
    mirror_chk = 0;
    m_axis_tready = 1'b1;
    chk("t5_mirror", mirror_errs, 0);
    chk("t5_ngrants", glog.size(), 8);
    for (int k = 0; k < glog.size() && k < 8; k++) chk($sformatf("t5_order%0d", k), glog[k], k % 4);
    for (int k = 0; k < 8; k++) chk_frame($sformatf("t5_frame%0d", k), k % 4, k / 4, 6 + 3 * (k % 4), 1'(k % 4 == 1));

    // cfg_enable dropped mid-frame: frame completes, no new grant until re-enabled.
    do_reset();
    load(2, 100, 1, 1'b0); drive(); #1; sample();
    step(); step();
    load(0, 3, 1, 1'b0); drive();
    n = 0;
    while (src_beat[2] < 10 && n < 200) begin step(); n++; end
    cfg_enable = 1'b0;
    n = 0;
    while (src_left[2] > 0 && n < 400) begin step(); n++; end
    chk("t6_frame_done", src_left[2], 0);
    repeat (5) step();
    chk("t6_hold_gv", grant_valid, 0);
    chk("t6_hold_grant", grant, 0);
    chk("t6_hold_ready", s_axis_tready, 0);
    cfg_enable = 1'b1;
    step();
    chk("t6_reenable", grant, 4'b0001);
    run_idle(100, "t6_done");
    chk_frame("t6_f2", 2, 0, 100, 1'b0);
    chk_frame("t6_f0", 0, 0, 3, 1'b0);

    // Asynchronous reset mid-frame, then arbitration restarts at stream 0.
    load(3, 50, 1, 1'b0); drive(); #1; sample();
    repeat (10) step();
    chk("t7_busy", grant, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_grant", grant, 0);
    chk("t7_gv", grant_valid, 0);
    chk("t7_mvalid", m_axis_tvalid, 0);
    chk("t7_sready", s_axis_tready, 0);
    for (int i = 0; i < S; i++) begin
      src_beat[i] = 0; src_frm[i] = 0; src_left[i] = 0;
    end
    drive();
    hs_q = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gv_prev = 1'b0;
    out_dat.delete(); out_last.delete(); out_user.delete();
    load(0, 2, 1, 1'b0); load(1, 2, 1, 1'b0); drive(); #1; sample();
    step();
    chk("t7_restart", grant, 4'b0001);
    run_idle(100, "t7_done");
    chk_frame("t7_f0", 0, 0, 2, 1'b0);
    chk_frame("t7_f1", 1, 0, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
